uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
Controller that sequences the pipeline from power-up. It holds the core in reset and receives a program image as a byte stream from the UART receiver. It assembles the bytes into 32-bit words, writes them into instruction memory through the fetch stage's load port, and verifies a checksum. On a good checksum it releases the core so execution starts at PC 0.

Parameters:
IMEM_DEPTH_WORDS, 1024, instruction memory depth in words; max accepted image length
ADDR_W, $clog2(IMEM_DEPTH_WORDS), word-address width (derived, not overridden)
TIMEOUT_CYCLES, 1000000, max idle cycles between bytes inside a frame before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_valid  in  1  single-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
imem_we  out  1  instruction memory write enable, one-cycle pulse per word
imem_addr  out  ADDR_W  word address for the write
imem_wdata  out  32  word to write
core_rst  out  1  reset to the pipeline; 1 = core held in reset
busy  out  1  frame in progress (WAIT_LEN1, LOAD, CHECK)
load_done  out  1  image loaded and verified; sticky until rst
load_error  out  1  last frame failed (length, timeout or checksum)

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). All outputs are registered.
- Reset values: state WAIT_LEN0, core_rst=1, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, load_done=0, load_error=0. Internal word/byte indices, checksum and timeout counter are all 0.
- Frame format: len_lo, len_hi (16-bit word count N, little-endian), then 4N data bytes (each word little-endian, first byte to bits 7:0), then 1 checksum byte. The checksum is the XOR of all 4N data bytes; length bytes are excluded.
- At most one byte per cycle. Back-to-back rx_valid must be accepted with no loss.
- WAIT_LEN0: on rx_valid, len[7:0]=rx_data, clear load_error, go to WAIT_LEN1.
- WAIT_LEN1: on rx_valid, len[15:8]=rx_data.
  - If the full len is 0 or greater than IMEM_DEPTH_WORDS, go to ERROR.
  - Otherwise go to LOAD, with word_idx=0, byte_idx=0, csum=0.
- LOAD: on each rx_valid, place the byte into lane byte_idx of the assembly buffer, csum ^= byte, then byte_idx++ (2-bit, wraps).
  - When byte_idx==3, in the next cycle: imem_we=1, imem_addr=word_idx, imem_wdata=the assembled word. Then word_idx++.
  - After the write of word N-1, go to CHECK.
  - imem_we is high for exactly one cycle per word. A byte arriving in the same cycle as that pulse is accepted normally.
- CHECK: on rx_valid, compare the byte with csum.
  - Equal: go to RUN. The next cycle core_rst=0 and load_done=1.
  - Not equal: go to ERROR.
- RUN: rx bytes are ignored, imem_we stays 0, core_rst stays 0. Only rst leaves this state.
- ERROR: load_error=1, core_rst=1, busy=0. The next rx_valid is treated as len_lo: the state goes to WAIT_LEN1 and load_error clears.
- Timeout:
  - The counter runs in WAIT_LEN1, LOAD and CHECK, and clears on every accepted byte and on every state entry.
  - On reaching TIMEOUT_CYCLES-1 with no rx_valid, go to ERROR.
  - If rx_valid arrives in the same cycle as expiry, the byte wins and no timeout occurs.
- rst mid-frame: outputs return to reset values the next cycle. Partially written imem contents are don't-care; the next frame overwrites from address 0.
- Widths: word_idx is ADDR_W+1 bits so that N=IMEM_DEPTH_WORDS compares without overflow. The length compare is done at 16 bits.

Decomposition:
- Shared pipeline package gets boot_state_type (enum WAIT_LEN0, WAIT_LEN1, LOAD, CHECK, RUN, ERROR) and the constant BOOT_LEN_BYTES=2.
- One sub-module: boot_timeout_counter, with clear/enable inputs, a TIMEOUT_CYCLES parameter and an expired output.
- The FSM, assembly buffer and checksum stay in uart_boot_loader.

Test Plan:
1. Bytes 01 00 13 00 00 00 13 -> one imem_we, addr 0, wdata 0x00000013, the cycle after the 4th data byte. core_rst falls and load_done=1 the cycle after the checksum byte.
2. Bytes 02 00 93 00 50 00 13 81 10 00 42 (correct checksum is 0x41) -> writes 0x00500093 at addr 0 and 0x00108113 at addr 1; then load_error=1, core_rst stays 1, load_done=0.
3. Bytes 01 04 (N=1025 > 1024) -> ERROR immediately, no imem_we. A following valid frame from scenario 1 loads and starts.
4. TIMEOUT_CYCLES=16: bytes 01 00 13 00, then 16 idle cycles -> load_error=1, no write. Repeat the same with rx_valid in the expiry cycle -> no error.
5. rst pulsed during LOAD of word 1 -> all outputs at reset values the next cycle. A fresh frame writes starting at addr 0.
6. Back-to-back bytes every cycle for N=4 with correct checksum -> 4 write pulses at addr 0..3, no byte dropped. Bytes sent in RUN produce no imem_we, and core_rst stays 0.

Source files
------------

// File: rtl/uart_boot_loader_pkg.sv
// rtl/uart_boot_loader_pkg.sv - shared types and constants for the UART boot loader
package uart_boot_loader_pkg;

    // Frame sequencing states of the loader.
    typedef enum logic [2:0] {
        WAIT_LEN0,
        WAIT_LEN1,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } boot_state_type;

    // Number of little-endian bytes carrying the word count at the head of a frame.
    localparam int BOOT_LEN_BYTES = 2;

endpackage

// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - byte receive strobe and instruction memory load port
interface uart_boot_loader_if #(
    parameter int IMEM_DEPTH_WORDS = 1024
);

    localparam int ADDR_W = $clog2(IMEM_DEPTH_WORDS);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Loader side: consumes received bytes, drives the memory write port.
    modport master (
        input  rx_valid,
        input  rx_data,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    // UART / memory side: supplies bytes, observes the write port.
    modport slave (
        output rx_valid,
        output rx_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/uart_boot_loader_timeout.sv
// rtl/uart_boot_loader_timeout.sv - inter-byte idle counter that flags a stalled frame
module boot_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count idle cycles while enabled; any accepted byte or state change restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Depends only on the registered count so the FSM can feed clear_i back without a loop.
    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - receives a UART program image, loads imem, releases the core on good checksum
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int IMEM_DEPTH_WORDS = 1024,
    parameter int TIMEOUT_CYCLES   = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    uart_boot_loader_if.master  bus,
    output logic                core_rst,
    output logic                busy,
    output logic                load_done,
    output logic                load_error
);

    localparam int               ADDR_W  = $clog2(IMEM_DEPTH_WORDS);
    localparam int               LEN_W   = 8 * BOOT_LEN_BYTES;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(IMEM_DEPTH_WORDS);

    boot_state_type    state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              to_enable;
    logic              to_clear;
    logic              to_expired;
    logic [LEN_W-1:0]  full_len;
    logic              last_word;

    // The top byte of the length arrives in WAIT_LEN1 and is combined with the stored low byte.
    assign full_len  = {bus.rx_data, len_q[7:0]};
    // word_idx is one bit wider than an address so N equal to the full depth still compares.
    assign last_word = (LEN_W'(word_idx_q) + 1'b1) == len_q;

    assign to_enable = (state_q == WAIT_LEN1) || (state_q == LOAD) || (state_q == CHECK);
    assign to_clear  = bus.rx_valid || (state_d != state_q);

    boot_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (to_clear),
        .enable_i (to_enable),
        .expired_o(to_expired)
    );

    // Next-state and registered-output logic; a byte arriving in the expiry cycle beats the timeout.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;

        unique case (state_q)
            WAIT_LEN0, ERROR: begin
                if (bus.rx_valid) begin
                    len_d   = {{(LEN_W-8){1'b0}}, bus.rx_data};
                    err_d   = 1'b0;
                    state_d = WAIT_LEN1;
                end
            end
            WAIT_LEN1: begin
                if (bus.rx_valid) begin
                    len_d = full_len;
                    if ((full_len == '0) || (full_len > DEPTH_L)) begin
                        state_d = ERROR;
                    end else begin
                        state_d    = LOAD;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        csum_d     = '0;
                    end
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            LOAD: begin
                if (bus.rx_valid) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = bus.rx_data;
                        2'd1: asm_d[15:8]  = bus.rx_data;
                        2'd2: asm_d[23:16] = bus.rx_data;
                        default: begin
                            // Lane 3 goes straight into the write word; the pulse fires next cycle.
                            we_d       = 1'b1;
                            addr_d     = word_idx_q[ADDR_W-1:0];
                            wdata_d    = {bus.rx_data, asm_q};
                            word_idx_d = word_idx_q + 1'b1;
                            if (last_word) begin
                                state_d = CHECK;
                            end
                        end
                    endcase
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        state_d    = RUN;
                        core_rst_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            RUN: begin
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        if (state_d == ERROR) begin
            err_d = 1'b1;
        end
        busy_d = (state_d == WAIT_LEN1) || (state_d == LOAD) || (state_d == CHECK);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_LEN0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign core_rst       = core_rst_q;
    assign busy           = busy_q;
    assign load_done      = done_q;
    assign load_error     = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for the UART boot loader
module tb_uart_boot_loader;

    localparam int DEPTH   = 1024;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    logic core_rst;
    logic busy;
    logic load_done;
    logic load_error;

    int checks = 0;
    int errors = 0;

    logic [9:0]  got_addr_q[$];
    logic [31:0] got_data_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  tx_q[$];

    uart_boot_loader_if #(.IMEM_DEPTH_WORDS(DEPTH)) bus ();

    uart_boot_loader #(
        .IMEM_DEPTH_WORDS(DEPTH),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_rst  (core_rst),
        .busy      (busy),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    // Memory-side monitor: record every write pulse.
    always @(posedge clk) begin
        #1;
        if (bus.imem_we === 1'b1) begin
            got_addr_q.push_back(bus.imem_addr);
            got_data_q.push_back(bus.imem_wdata);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs after a falling edge, return at the next falling edge.
    task automatic cyc(input bit v, input logic [7:0] d);
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic clear_logs();
        got_addr_q.delete();
        got_data_q.delete();
        exp_data_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_core_rst"}, core_rst, 1);
        check_val({tag, "_we"}, bus.imem_we, 0);
        check_val({tag, "_addr"}, bus.imem_addr, 0);
        check_val({tag, "_wdata"}, bus.imem_wdata, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, load_done, 0);
        check_val({tag, "_err"}, load_error, 0);
    endtask

    // Expected writes: word i of the image lands at address i, in order.
    task automatic compare_writes(input string tag);
        int n;
        check_val({tag, "_nwrites"}, got_data_q.size(), exp_data_q.size());
        n = (got_data_q.size() < exp_data_q.size()) ? got_data_q.size() : exp_data_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_addr%0d", tag, i), got_addr_q[i], i);
            check_val($sformatf("%s_data%0d", tag, i), got_data_q[i], exp_data_q[i]);
        end
        got_addr_q.delete();
        got_data_q.delete();
        exp_data_q.delete();
    endtask

    task automatic send_tx(input int max_gap);
        foreach (tx_q[i]) begin
            repeat ($urandom_range(0, max_gap)) cyc(1'b0, 8'h00);
            cyc(1'b1, tx_q[i]);
        end
        tx_q.delete();
    endtask

    // Build a frame from a random image, send it, and judge the outcome from the frame rules.
    task automatic run_random_frame(input int n, input bit corrupt, input int max_gap, input string tag);
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  csum;
        bit          valid;
        bit          ok;
        logic [15:0] len16;
        clear_logs();
        tx_q.delete();
        len16 = 16'(n);
        tx_q.push_back(len16[7:0]);
        tx_q.push_back(len16[15:8]);
        valid = (n >= 1) && (n <= DEPTH);
        csum  = 8'h00;
        if (valid) begin
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                exp_data_q.push_back(w);
                for (int k = 0; k < 4; k++) begin
                    b = 8'(w >> (8 * k));
                    tx_q.push_back(b);
                    csum = csum ^ b;
                end
            end
            tx_q.push_back(corrupt ? (csum ^ 8'($urandom_range(1, 255))) : csum);
        end
        send_tx(max_gap);
        cyc(1'b0, 8'h00);
        compare_writes(tag);
        ok = valid && !corrupt;
        check_val({tag, "_done"}, load_done, ok);
        check_val({tag, "_core_rst"}, core_rst, !ok);
        check_val({tag, "_err"}, load_error, !ok);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    task automatic send_fixed_frame1();
        cyc(1'b1, 8'h01); cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h13); cyc(1'b1, 8'h00); cyc(1'b1, 8'h00); cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h13);
    endtask

    initial begin
        int n;
        bit corrupt;
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        do_reset();
        check_reset_outputs("reset");

        // Single-word image with exact pulse timing.
        cyc(1'b1, 8'h01);
        check_val("s1_busy_len0", busy, 1);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h13); cyc(1'b1, 8'h00); cyc(1'b1, 8'h00);
        check_val("s1_we_early", bus.imem_we, 0);
        cyc(1'b1, 8'h00);
        check_val("s1_we", bus.imem_we, 1);
        check_val("s1_addr", bus.imem_addr, 0);
        check_val("s1_wdata", bus.imem_wdata, 32'h0000_0013);
        check_val("s1_core_rst_pre", core_rst, 1);
        cyc(1'b1, 8'h13);
        check_val("s1_we_single", bus.imem_we, 0);
        check_val("s1_core_rst", core_rst, 0);
        check_val("s1_done", load_done, 1);
        check_val("s1_err", load_error, 0);
        check_val("s1_busy", busy, 0);

        // Back-to-back bytes, then bytes in RUN are ignored.
        do_reset();
        run_random_frame(4, 1'b0, 0, "s6");
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom));
        check_val("s6_run_writes", got_data_q.size(), 0);
        check_val("s6_run_core_rst", core_rst, 0);
        check_val("s6_run_done", load_done, 1);

        // Bad checksum.
        do_reset();
        tx_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h42};
        send_tx(0);
        cyc(1'b0, 8'h00);
        exp_data_q.push_back(32'h0050_0093);
        exp_data_q.push_back(32'h0010_8113);
        compare_writes("s2");
        check_val("s2_err", load_error, 1);
        check_val("s2_core_rst", core_rst, 1);
        check_val("s2_done", load_done, 0);

        // Oversized length, then recovery with a good frame.
        do_reset();
        cyc(1'b1, 8'h01); cyc(1'b1, 8'h04);
        check_val("s3_err", load_error, 1);
        check_val("s3_busy", busy, 0);
        send_fixed_frame1();
        check_val("s3_done", load_done, 1);
        check_val("s3_core_rst", core_rst, 0);
        exp_data_q.push_back(32'h0000_0013);
        compare_writes("s3");

        // Timeout expiry after exactly TIMEOUT idle cycles.
        do_reset();
        cyc(1'b1, 8'h01); cyc(1'b1, 8'h00); cyc(1'b1, 8'h13); cyc(1'b1, 8'h00);
        repeat (TIMEOUT - 1) cyc(1'b0, 8'h00);
        check_val("s4_err_before", load_error, 0);
        check_val("s4_busy_before", busy, 1);
        cyc(1'b0, 8'h00);
        check_val("s4_err", load_error, 1);
        check_val("s4_busy", busy, 0);
        check_val("s4_nwrites", got_data_q.size(), 0);

        // A byte in the expiry cycle wins.
        do_reset();
        cyc(1'b1, 8'h01); cyc(1'b1, 8'h00); cyc(1'b1, 8'h13); cyc(1'b1, 8'h00);
        repeat (TIMEOUT - 1) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h00);
        check_val("s4b_err", load_error, 0);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h13);
        check_val("s4b_done", load_done, 1);
        exp_data_q.push_back(32'h0000_0013);
        compare_writes("s4b");

        // Reset in the middle of word 1.
        do_reset();
        cyc(1'b1, 8'h02); cyc(1'b1, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom));
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        check_reset_outputs("s5");
        rst = 1'b0;
        run_random_frame(2, 1'b0, 2, "s5");

        // Randomized frames: lengths, gaps and checksum corruption.
        do_reset();
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 7))
                0:       n = 0;
                1:       n = DEPTH + 1;
                2:       n = 65535;
                default: n = $urandom_range(1, 6);
            endcase
            corrupt = ($urandom_range(0, 2) == 0);
            run_random_frame(n, corrupt, 3, $sformatf("rnd%0d", it));
            if (load_done) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
